cpu_run_monitor: RTL and testbench

- Synthesizable run monitor attached beside `cpu`. It watches the retire, write-back and store streams, and counts cycles and retired instructions.
- Pass/fail comes from parametrised register and memory checkpoints. Run end comes from the END_SENTINEL instruction or a cycle timeout.
- Generalises bench-only checking (one register check, one memory check, fixed sentinel) into reusable hardware for FPGA bring-up and regression benches.

---
 rtl/cpu_mon_pkg.sv | 21 ++
 rtl/cpu_run_monitor_if.sv | 28 ++
 rtl/cpu_mon_chk_slot.sv | 37 +++
 rtl/cpu_run_monitor.sv | 206 ++++++++++++++++++++
 tb/tb_cpu_run_monitor.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_mon_pkg.sv
// Shared types and constants for the cpu run monitor.
package cpu_mon_pkg;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RUN     = 2'd1;
    localparam logic [1:0] DONE    = 2'd2;
    localparam logic [1:0] TIMEOUT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = IDLE,
        ST_RUN     = RUN,
        ST_DONE    = DONE,
        ST_TIMEOUT = TIMEOUT
    } state_e;

    // jal x0,0 : the conventional "spin here forever" end-of-test instruction
    localparam logic [31:0] DEFAULT_END_SENTINEL = 32'h0000_006F;

    localparam int unsigned REG_IDX_W = 5;

endpackage

// File: rtl/cpu_run_monitor_if.sv
// Retire / write-back / store streams observed from the cpu core.
interface cpu_run_monitor_if #(
    parameter int unsigned XLEN = 32
) ();
    import cpu_mon_pkg::*;

    logic                 retire_valid;
    logic [XLEN-1:0]      retire_pc;
    logic [XLEN-1:0]      retire_instr;
    logic                 wb_valid;
    logic [REG_IDX_W-1:0] wb_rd;
    logic [XLEN-1:0]      wb_data;
    logic                 store_valid;
    logic [XLEN-1:0]      store_addr;
    logic [XLEN-1:0]      store_data;

    modport master (
        output retire_valid, retire_pc, retire_instr,
        output wb_valid, wb_rd, wb_data,
        output store_valid, store_addr, store_data
    );

    modport slave (
        input retire_valid, retire_pc, retire_instr,
        input wb_valid, wb_rd, wb_data,
        input store_valid, store_addr, store_data
    );
endinterface

// File: rtl/cpu_mon_chk_slot.sv
// One checkpoint: a hit bit set by a matching key with equal data, cleared by a
// matching key with different data, so it reflects the last write to that key.
module cpu_mon_chk_slot #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned KEY_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic             valid,
    input  logic [KEY_W-1:0] key,
    input  logic [KEY_W-1:0] exp_key,
    input  logic [XLEN-1:0]  data,
    input  logic [XLEN-1:0]  exp_val,
    output logic             hit,
    output logic             hit_nxt_c
);

    always_comb begin
        hit_nxt_c = hit;
        if (clear) begin
            hit_nxt_c = 1'b0;
        end else if (en && valid && (key == exp_key)) begin
            hit_nxt_c = (data == exp_val);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit <= 1'b0;
        end else begin
            hit <= hit_nxt_c;
        end
    end

endmodule

// File: rtl/cpu_run_monitor.sv
// Run monitor beside the cpu: counts cycles/retirements, tracks register and memory
// checkpoints, and ends a run on the sentinel instruction or a cycle timeout.
// Optional misaligned-store tracking is enabled with `define CPU_MON_MISALIGN_EN.
module cpu_run_monitor
    import cpu_mon_pkg::*;
#(
    parameter int unsigned     XLEN           = 32,
    parameter int unsigned     NUM_REG_CHECKS = 2,
    parameter int unsigned     NUM_MEM_CHECKS = 2,
    parameter int unsigned     CNT_WIDTH      = 32,
    parameter int unsigned     MAX_CYCLES     = 20,
    parameter logic [XLEN-1:0] END_SENTINEL   = XLEN'(DEFAULT_END_SENTINEL)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    cpu_run_monitor_if.slave                    mon,
    input  logic [REG_IDX_W*NUM_REG_CHECKS-1:0] reg_chk_idx,
    input  logic [XLEN*NUM_REG_CHECKS-1:0]      reg_chk_val,
    input  logic [XLEN*NUM_MEM_CHECKS-1:0]      mem_chk_addr,
    input  logic [XLEN*NUM_MEM_CHECKS-1:0]      mem_chk_val,
    output logic                                busy,
    output logic                                done,
    output logic                                timeout,
    output logic                                pass,
    output logic                                fail,
    output logic [NUM_REG_CHECKS-1:0]           reg_hit,
    output logic [NUM_MEM_CHECKS-1:0]           mem_hit,
    output logic [CNT_WIDTH-1:0]                cycle_count,
    output logic [CNT_WIDTH-1:0]                instr_count,
    output logic [XLEN-1:0]                     end_pc
`ifdef CPU_MON_MISALIGN_EN
    ,
    output logic [CNT_WIDTH-1:0]                misalign_count,
    output logic [XLEN-1:0]                     first_misalign_addr
`endif
);

    localparam int unsigned ADDR_KEY_W = XLEN - 2;

    state_e state, state_nxt;
    logic   start_run_c;
    logic   run_c;
    logic   sentinel_c;
    logic   tmo_c;
    logic   mis_ok_c;
    logic   pass_nxt_c;
    logic [NUM_REG_CHECKS-1:0] reg_hit_nxt;
    logic [NUM_MEM_CHECKS-1:0] mem_hit_nxt;

    assign run_c      = (state == ST_RUN);
    assign sentinel_c = run_c && mon.retire_valid && (mon.retire_instr == END_SENTINEL);
    assign tmo_c      = run_c && !sentinel_c &&
                        (cycle_count == CNT_WIDTH'(MAX_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Sentinel has priority over timeout when both land on the same cycle
    always_comb begin
        state_nxt   = state;
        start_run_c = 1'b0;
        unique case (state)
            ST_IDLE, ST_DONE, ST_TIMEOUT: begin
                if (start) begin
                    state_nxt   = ST_RUN;
                    start_run_c = 1'b1;
                end
            end
            ST_RUN: begin
                if (sentinel_c) begin
                    state_nxt = ST_DONE;
                end else if (tmo_c) begin
                    state_nxt = ST_TIMEOUT;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Register checkpoints; an x0 slot compares a constant zero from the first RUN cycle
    for (genvar i = 0; i < int'(NUM_REG_CHECKS); i++) begin : g_reg
        logic [REG_IDX_W-1:0] idx;
        logic                 zero_idx;
        logic                 valid;
        logic [REG_IDX_W-1:0] key;
        logic [XLEN-1:0]      data;

        assign idx      = reg_chk_idx[REG_IDX_W*i +: REG_IDX_W];
        assign zero_idx = (idx == '0);
        assign valid    = zero_idx ? 1'b1 : (mon.wb_valid && (mon.wb_rd != '0));
        assign key      = zero_idx ? '0 : mon.wb_rd;
        assign data     = zero_idx ? '0 : mon.wb_data;

        cpu_mon_chk_slot #(.XLEN(XLEN), .KEY_W(REG_IDX_W)) u_slot (
            .clk       (clk),
            .reset     (reset),
            .clear     (start_run_c),
            .en        (run_c),
            .valid     (valid),
            .key       (key),
            .exp_key   (idx),
            .data      (data),
            .exp_val   (reg_chk_val[XLEN*i +: XLEN]),
            .hit       (reg_hit[i]),
            .hit_nxt_c (reg_hit_nxt[i])
        );
    end

    // Memory checkpoints match on the word address only
    for (genvar i = 0; i < int'(NUM_MEM_CHECKS); i++) begin : g_mem
        logic [1:0] unused_chk_lsb;
        assign unused_chk_lsb = mem_chk_addr[XLEN*i +: 2];

        cpu_mon_chk_slot #(.XLEN(XLEN), .KEY_W(ADDR_KEY_W)) u_slot (
            .clk       (clk),
            .reset     (reset),
            .clear     (start_run_c),
            .en        (run_c),
            .valid     (mon.store_valid),
            .key       (mon.store_addr[XLEN-1:2]),
            .exp_key   (mem_chk_addr[XLEN*i+2 +: ADDR_KEY_W]),
            .data      (mon.store_data),
            .exp_val   (mem_chk_val[XLEN*i +: XLEN]),
            .hit       (mem_hit[i]),
            .hit_nxt_c (mem_hit_nxt[i])
        );
    end

`ifdef CPU_MON_MISALIGN_EN
    logic mis_store_c;
    assign mis_store_c = run_c && mon.store_valid && (mon.store_addr[1:0] != 2'b00);
    assign mis_ok_c    = (misalign_count == '0) && !mis_store_c;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            misalign_count      <= '0;
            first_misalign_addr <= '0;
        end else if (start_run_c) begin
            misalign_count      <= '0;
            first_misalign_addr <= '0;
        end else if (mis_store_c) begin
            if (misalign_count == '0) begin
                first_misalign_addr <= mon.store_addr;
            end
            if (misalign_count != '1) begin
                misalign_count <= misalign_count + CNT_WIDTH'(1);
            end
        end
    end
`else
    logic [1:0] unused_store_lsb;
    assign unused_store_lsb = mon.store_addr[1:0];
    assign mis_ok_c         = 1'b1;
`endif

    assign pass_nxt_c = (&reg_hit_nxt) && (&mem_hit_nxt) && mis_ok_c;

    // Counters and status; everything holds outside RUN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            cycle_count <= '0;
            instr_count <= '0;
            end_pc      <= '0;
        end else begin
            busy <= (state_nxt == ST_RUN);
            if (start_run_c) begin
                done        <= 1'b0;
                timeout     <= 1'b0;
                pass        <= 1'b0;
                fail        <= 1'b0;
                cycle_count <= '0;
                instr_count <= '0;
                end_pc      <= '0;
            end else if (run_c) begin
                if (cycle_count != '1) begin
                    cycle_count <= cycle_count + CNT_WIDTH'(1);
                end
                if (mon.retire_valid && (instr_count != '1)) begin
                    instr_count <= instr_count + CNT_WIDTH'(1);
                end
                if (sentinel_c) begin
                    done   <= 1'b1;
                    end_pc <= mon.retire_pc;
                    pass   <= pass_nxt_c;
                    fail   <= !pass_nxt_c;
                end else if (tmo_c) begin
                    timeout <= 1'b1;
                    pass    <= 1'b0;
                    fail    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Directed and random runs of cpu_run_monitor checked against a run-level model.
module tb_cpu_run_monitor;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NR   = 2;
    localparam int unsigned NM   = 2;
    localparam int unsigned CW   = 32;
    localparam int unsigned MAXC = 20;
    localparam int unsigned LEN  = MAXC + 2;
    localparam logic [31:0] SENT = 32'h0000_006F;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic [5*NR-1:0]    reg_chk_idx  = '0;
    logic [XLEN*NR-1:0] reg_chk_val  = '0;
    logic [XLEN*NM-1:0] mem_chk_addr = '0;
    logic [XLEN*NM-1:0] mem_chk_val  = '0;
    logic busy, done, timeout, pass, fail;
    logic [NR-1:0]   reg_hit;
    logic [NM-1:0]   mem_hit;
    logic [CW-1:0]   cycle_count, instr_count;
    logic [XLEN-1:0] end_pc;
`ifdef CPU_MON_MISALIGN_EN
    logic [CW-1:0]   misalign_count;
    logic [XLEN-1:0] first_misalign_addr;
`endif

    cpu_run_monitor_if #(.XLEN(XLEN)) mon_if ();

    cpu_run_monitor #(
        .XLEN(XLEN), .NUM_REG_CHECKS(NR), .NUM_MEM_CHECKS(NM),
        .CNT_WIDTH(CW), .MAX_CYCLES(MAXC), .END_SENTINEL(SENT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .mon(mon_if.slave),
        .reg_chk_idx(reg_chk_idx), .reg_chk_val(reg_chk_val),
        .mem_chk_addr(mem_chk_addr), .mem_chk_val(mem_chk_val),
        .busy(busy), .done(done), .timeout(timeout), .pass(pass), .fail(fail),
        .reg_hit(reg_hit), .mem_hit(mem_hit),
        .cycle_count(cycle_count), .instr_count(instr_count), .end_pc(end_pc)
`ifdef CPU_MON_MISALIGN_EN
        , .misalign_count(misalign_count), .first_misalign_addr(first_misalign_addr)
`endif
    );

    always #5 clk = ~clk;

    // One program = per-cycle stream events, indexed by RUN cycle
    logic        ev_rv [LEN];
    logic [31:0] ev_pc [LEN];
    logic [31:0] ev_in [LEN];
    logic        ev_wv [LEN];
    logic [4:0]  ev_rd [LEN];
    logic [31:0] ev_wd [LEN];
    logic        ev_sv [LEN];
    logic [31:0] ev_sa [LEN];
    logic [31:0] ev_sd [LEN];

    logic          e_done, e_tmo, e_pass, e_fail;
    logic [NR-1:0] e_reg_hit;
    logic [NM-1:0] e_mem_hit;
    int unsigned   e_cyc, e_instr, e_mis;
    logic [31:0]   e_end_pc, e_mis_addr;

    int n_pass   = 0;
    int n_checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic idle_streams();
        mon_if.retire_valid = 1'b0; mon_if.retire_pc = '0; mon_if.retire_instr = '0;
        mon_if.wb_valid = 1'b0; mon_if.wb_rd = '0; mon_if.wb_data = '0;
        mon_if.store_valid = 1'b0; mon_if.store_addr = '0; mon_if.store_data = '0;
    endtask

    task automatic clear_prog(input logic rv_all);
        for (int c = 0; c < int'(LEN); c++) begin
            ev_rv[c] = rv_all; ev_pc[c] = 32'(4 * c); ev_in[c] = NOP;
            ev_wv[c] = 1'b0; ev_rd[c] = '0; ev_wd[c] = '0;
            ev_sv[c] = 1'b0; ev_sa[c] = '0; ev_sd[c] = '0;
        end
    endtask

    task automatic set_wb(input int c, input logic [4:0] rd, input logic [31:0] d);
        ev_wv[c] = 1'b1; ev_rd[c] = rd; ev_wd[c] = d;
    endtask

    task automatic set_st(input int c, input logic [31:0] a, input logic [31:0] d);
        ev_sv[c] = 1'b1; ev_sa[c] = a; ev_sd[c] = d;
    endtask

    // x6=0x10, x7=0x20, [0x40]=DEADBEEF, [0x44]=0x55, sentinel at pc 0x1C
    task automatic prog_basic();
        clear_prog(1'b0);
        for (int c = 0; c < 8; c++) ev_rv[c] = 1'b1;
        set_wb(1, 5'd6, 32'h10);
        set_wb(2, 5'd7, 32'h20);
        set_st(3, 32'h40, 32'hDEAD_BEEF);
        set_st(4, 32'h44, 32'h55);
        ev_in[7] = SENT;
    endtask

    task automatic cfg_basic();
        reg_chk_idx  = {5'd7, 5'd6};
        reg_chk_val  = {32'h20, 32'h10};
        mem_chk_addr = {32'h44, 32'h40};
        mem_chk_val  = {32'h55, 32'hDEAD_BEEF};
    endtask

    // Run-level reference: replay the program until the sentinel or the cycle budget
    task automatic model();
        logic [31:0] regs [32];
        bit          wr   [32];
        logic [31:0] mem  [logic [29:0]];
        logic [4:0]  idx;
        logic [31:0] val, adr;
        for (int r = 0; r < 32; r++) begin regs[r] = '0; wr[r] = 1'b0; end
        e_done = 0; e_tmo = 0; e_cyc = 0; e_instr = 0; e_end_pc = '0; e_mis = 0; e_mis_addr = '0;
        for (int c = 0; c < int'(LEN); c++) begin
            if (ev_rv[c]) e_instr++;
            if (ev_wv[c] && ev_rd[c] != 0) begin regs[ev_rd[c]] = ev_wd[c]; wr[ev_rd[c]] = 1'b1; end
            if (ev_sv[c]) begin
                mem[ev_sa[c][31:2]] = ev_sd[c];
                if (ev_sa[c][1:0] != 0) begin
                    if (e_mis == 0) e_mis_addr = ev_sa[c];
                    e_mis++;
                end
            end
            if (ev_rv[c] && ev_in[c] == SENT) begin
                e_done = 1; e_end_pc = ev_pc[c]; e_cyc = c + 1; break;
            end
            if (c == int'(MAXC) - 1) begin e_tmo = 1; e_cyc = MAXC; break; end
        end
        for (int i = 0; i < int'(NR); i++) begin
            idx = reg_chk_idx[5*i +: 5];
            val = reg_chk_val[32*i +: 32];
            e_reg_hit[i] = (idx == 0) ? (val == 0) : (wr[idx] && regs[idx] == val);
        end
        for (int i = 0; i < int'(NM); i++) begin
            adr = mem_chk_addr[32*i +: 32];
            val = mem_chk_val[32*i +: 32];
            e_mem_hit[i] = mem.exists(adr[31:2]) && (mem[adr[31:2]] == val);
        end
        e_pass = e_done && (&e_reg_hit) && (&e_mem_hit);
`ifdef CPU_MON_MISALIGN_EN
        if (e_mis != 0) e_pass = 1'b0;
`endif
        e_fail = (e_done || e_tmo) && !e_pass;
    endtask

    task automatic play(input string tag);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, ".busy_run"}, 64'(busy), 64'd1);
        for (int c = 0; c < int'(LEN); c++) begin
            mon_if.retire_valid = ev_rv[c]; mon_if.retire_pc = ev_pc[c]; mon_if.retire_instr = ev_in[c];
            mon_if.wb_valid = ev_wv[c]; mon_if.wb_rd = ev_rd[c]; mon_if.wb_data = ev_wd[c];
            mon_if.store_valid = ev_sv[c]; mon_if.store_addr = ev_sa[c]; mon_if.store_data = ev_sd[c];
            @(posedge clk); #1;
        end
        idle_streams();
    endtask

    task automatic check_run(input string tag);
        model();
        chk({tag, ".busy"},    64'(busy),        64'd0);
        chk({tag, ".done"},    64'(done),        64'(e_done));
        chk({tag, ".timeout"}, 64'(timeout),     64'(e_tmo));
        chk({tag, ".pass"},    64'(pass),        64'(e_pass));
        chk({tag, ".fail"},    64'(fail),        64'(e_fail));
        chk({tag, ".reg_hit"}, 64'(reg_hit),     64'(e_reg_hit));
        chk({tag, ".mem_hit"}, 64'(mem_hit),     64'(e_mem_hit));
        chk({tag, ".cycles"},  64'(cycle_count), 64'(e_cyc));
        chk({tag, ".instrs"},  64'(instr_count), 64'(e_instr));
        chk({tag, ".end_pc"},  64'(end_pc),      64'(e_end_pc));
`ifdef CPU_MON_MISALIGN_EN
        chk({tag, ".mis_cnt"},  64'(misalign_count),      64'(e_mis));
        chk({tag, ".mis_addr"}, 64'(first_misalign_addr), 64'(e_mis_addr));
`endif
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({busy, done, timeout, pass, fail, reg_hit, mem_hit}) |
               64'(cycle_count) | 64'(instr_count) | 64'(end_pc);
    endfunction

    initial begin
        idle_streams();
        #3;
        chk("reset.outputs", all_outs(), 64'd0);
        #9 reset = 1'b1;
        @(posedge clk); #1;
        chk("reset.idle_busy", 64'(busy), 64'd0);

        // Full pass
        cfg_basic(); prog_basic();
        play("basic"); check_run("basic");
        chk("basic.done_k",   64'(done),        64'd1);
        chk("basic.pass_k",   64'(pass),        64'd1);
        chk("basic.endpc_k",  64'(end_pc),      64'h1C);
        chk("basic.instr_k",  64'(instr_count), 64'd8);

        // Wrong register expectation
        reg_chk_val[31:0] = 32'h11;
        play("badreg"); check_run("badreg");
        chk("badreg.reg_hit_k", 64'(reg_hit), 64'b10);
        chk("badreg.fail_k",    64'(fail),    64'd1);

        // No sentinel at all
        cfg_basic(); clear_prog(1'b1);
        play("tmo"); check_run("tmo");
        chk("tmo.timeout_k", 64'(timeout),     64'd1);
        chk("tmo.cycles_k",  64'(cycle_count), 64'd20);

        // Memory word overwritten with a different value; ignored sentinel with retire_valid=0
        prog_basic();
        set_st(5, 32'h40, 32'h1234_5678);
        ev_in[6] = SENT; ev_rv[6] = 1'b0;
        play("memclr"); check_run("memclr");
        chk("memclr.mem_hit_k", 64'(mem_hit), 64'b10);
        chk("memclr.pass_k",    64'(pass),    64'd0);

        // Sentinel on the last budgeted cycle beats the timeout
        clear_prog(1'b1);
        ev_in[MAXC-1] = SENT;
        play("edge"); check_run("edge");
        chk("edge.done_k",    64'(done),    64'd1);
        chk("edge.timeout_k", 64'(timeout), 64'd0);

        // x0 checkpoint with zero expectation
        reg_chk_idx = {5'd0, 5'd0}; reg_chk_val = {32'h0, 32'h5};
        prog_basic(); set_wb(5, 5'd0, 32'h5);
        play("x0"); check_run("x0");

        // Abort mid-run by reset
        cfg_basic(); prog_basic();
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        for (int c = 0; c < 7; c++) begin
            mon_if.retire_valid = 1'b1; mon_if.retire_instr = NOP;
            @(posedge clk); #1;
        end
        idle_streams();
        reset = 1'b0; #1;
        chk("abort.outputs", all_outs(), 64'd0);
        #2 reset = 1'b1;
        @(posedge clk); #1;
        play("rerun1"); check_run("rerun1");
        play("rerun2"); check_run("rerun2");
        chk("rerun2.cycles_k", 64'(cycle_count), 64'd8);

`ifdef CPU_MON_MISALIGN_EN
        prog_basic(); set_st(5, 32'h42, 32'hDEAD_BEEF);
        play("mis"); check_run("mis");
        chk("mis.cnt_k",  64'(misalign_count),      64'd1);
        chk("mis.addr_k", 64'(first_misalign_addr), 64'h42);
        chk("mis.fail_k", 64'(fail),                64'd1);
`endif

        // Random programs and checkpoint sets
        for (int t = 0; t < 10; t++) begin
            int n;
            n = int'($urandom_range(1, LEN));
            clear_prog(1'b0);
            for (int c = 0; c < n; c++) begin
                ev_rv[c] = ($urandom_range(0, 3) != 0);
                ev_pc[c] = 32'($urandom_range(0, 255)) << 2;
                ev_in[c] = ($urandom_range(0, 15) == 0) ? SENT : NOP;
                if ($urandom_range(0, 1) == 1)
                    set_wb(c, 5'($urandom_range(0, 3)), 32'($urandom_range(0, 3)));
                if ($urandom_range(0, 2) == 0)
                    set_st(c, 32'h40 + 32'(4 * $urandom_range(0, 2))
                              + (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'd0),
                           32'($urandom_range(1, 3)));
            end
            if ($urandom_range(0, 1) == 1) begin ev_rv[n-1] = 1'b1; ev_in[n-1] = SENT; end
            for (int i = 0; i < int'(NR); i++) begin
                reg_chk_idx[5*i +: 5]  = 5'($urandom_range(0, 3));
                reg_chk_val[32*i +: 32] = 32'($urandom_range(0, 3));
            end
            for (int i = 0; i < int'(NM); i++) begin
                mem_chk_addr[32*i +: 32] = 32'h40 + 32'(4 * $urandom_range(0, 2));
                mem_chk_val[32*i +: 32]  = 32'($urandom_range(1, 3));
            end
            play($sformatf("rnd%0d", t)); check_run($sformatf("rnd%0d", t));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
